// File: rtl/sdram_burst_read.sv
// SDRAM read-burst engine: ACTIVE / READ / BURST STOP / PRECHARGE per open row,
// splitting requests at page boundaries and strobing every returned word.
module sdram_burst_read #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned BANK_W  = 2,
  parameter int unsigned ROW_W   = 13,
  parameter int unsigned COL_W   = 9,
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned CAS_LAT = 3,
  parameter int unsigned T_RCD   = 2,
  parameter int unsigned T_RP    = 2
) (
  input  logic                            rd_clk,
  input  logic                            rd_rst_n,
  input  logic                            init_end,
  input  logic                            rd_en,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   rd_addr,
  input  logic [LEN_W-1:0]                rd_bst_len,
  input  logic [DATA_W-1:0]               rd_data,
  output logic                            rd_ack,
  output logic                            rd_end,
  output logic                            rd_busy,
  output logic [3:0]                      rd_sdram_cmd,
  output logic [BANK_W-1:0]               rd_sdram_bank,
  output logic [ROW_W-1:0]                rd_sdram_addr,
  output logic [DATA_W-1:0]               rd_sdram_data
);

  localparam int unsigned AW   = BANK_W + ROW_W + COL_W;
  // Segment width must hold both a full page and the largest request.
  localparam int unsigned SW   = (LEN_W > COL_W + 1) ? LEN_W : COL_W + 1;
  localparam int unsigned CW   = SW + 2;
  localparam int unsigned PAGE = 2 ** COL_W;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_BST  = 4'b0110;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1024);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_TRCD, S_RD, S_DATA, S_PRE, S_TRP, S_END
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [AW-1:0]       cur_q, cur_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ROW_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ack_q, ack_d;
  logic                end_q, end_d;
  logic                busy_q, busy_d;

  logic [COL_W-1:0]    cur_col_c;
  logic [SW-1:0]       left_c, rem_ext_c, seg_c;
  logic [CW-1:0]       cnt_nxt_c, ack_end_c;
  logic                sample_c;

  // Words left in the current page versus words left overall.
  always_comb begin
    cur_col_c = cur_q[COL_W-1:0];
    left_c    = SW'(PAGE) - SW'(cur_col_c);
    rem_ext_c = SW'(rem_q);
    seg_c     = (rem_ext_c < left_c) ? rem_ext_c : left_c;
    cnt_nxt_c = cyc_q + CW'(1);
    ack_end_c = CW'(CAS_LAT) + CW'(seg_c);
    sample_c  = ((state_q == S_RD) || (state_q == S_DATA)) &&
                (cyc_q >= CW'(CAS_LAT)) && (cyc_q < ack_end_c);
  end

  // Next-state and registered-output logic; cyc counts cycles within a phase.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    cmd_d   = CMD_NOP;
    bank_d  = '0;
    addr_d  = '0;
    data_d  = data_q;
    ack_d   = 1'b0;
    end_d   = 1'b0;

    if (sample_c) begin
      data_d = rd_data;
      ack_d  = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (rd_en && init_end) begin
          cur_d = rd_addr;
          rem_d = rd_bst_len;
          cyc_d = '0;
          if (rd_bst_len == '0) begin
            state_d = S_END;
            end_d   = 1'b1;
          end else begin
            state_d = S_ACT;
            cmd_d   = CMD_ACT;
            bank_d  = rd_addr[AW-1 -: BANK_W];
            addr_d  = rd_addr[COL_W +: ROW_W];
          end
        end
      end
      S_ACT, S_TRCD: begin
        if (cnt_nxt_c == CW'(T_RCD)) begin
          state_d = S_RD;
          cyc_d   = '0;
          cmd_d   = CMD_READ;
          bank_d  = cur_q[AW-1 -: BANK_W];
          addr_d  = ROW_W'(cur_col_c);
        end else begin
          state_d = S_TRCD;
          cyc_d   = cnt_nxt_c;
        end
      end
      S_RD, S_DATA: begin
        state_d = S_DATA;
        cyc_d   = cnt_nxt_c;
        if (cnt_nxt_c == CW'(seg_c)) begin
          cmd_d = CMD_BST;
        end
        if (cnt_nxt_c == ack_end_c) begin
          state_d = S_PRE;
          cyc_d   = '0;
          cmd_d   = CMD_PRE;
          addr_d  = ADDR_A10;
          rem_d   = rem_q - LEN_W'(seg_c);
          cur_d   = cur_q + AW'(seg_c);
        end
      end
      S_PRE, S_TRP: begin
        if (cnt_nxt_c == CW'(T_RP)) begin
          cyc_d = '0;
          if (rem_q != '0) begin
            state_d = S_ACT;
            cmd_d   = CMD_ACT;
            bank_d  = cur_q[AW-1 -: BANK_W];
            addr_d  = cur_q[COL_W +: ROW_W];
          end else begin
            state_d = S_END;
            end_d   = 1'b1;
          end
        end else begin
          state_d = S_TRP;
          cyc_d   = cnt_nxt_c;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops everything to IDLE/NOP at once.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      cur_q   <= '0;
      rem_q   <= '0;
      cmd_q   <= CMD_NOP;
      bank_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      cmd_q   <= cmd_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  assign rd_sdram_cmd  = cmd_q;
  assign rd_sdram_bank = bank_q;
  assign rd_sdram_addr = addr_q;
  assign rd_sdram_data = data_q;
  assign rd_ack        = ack_q;
  assign rd_end        = end_q;
  assign rd_busy       = busy_q;

endmodule

// File: tb/tb_sdram_burst_read.sv
// Bench for sdram_burst_read: SDRAM read model, event recorder, directed vectors.
module tb_sdram_burst_read;

  localparam int CL = 3;
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] ACT  = 4'b0011;
  localparam logic [3:0] READ = 4'b0101;
  localparam logic [3:0] BST  = 4'b0110;
  localparam logic [3:0] PRE  = 4'b0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic        rd_en = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [9:0]  rd_bst_len = '0;
  logic [15:0] rd_data;
  logic        rd_ack, rd_end, rd_busy;
  logic [3:0]  rd_sdram_cmd;
  logic [1:0]  rd_sdram_bank;
  logic [12:0] rd_sdram_addr;
  logic [15:0] rd_sdram_data;

  sdram_burst_read dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .init_end(init_end), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_bst_len(rd_bst_len), .rd_data(rd_data),
    .rd_ack(rd_ack), .rd_end(rd_end), .rd_busy(rd_busy),
    .rd_sdram_cmd(rd_sdram_cmd), .rd_sdram_bank(rd_sdram_bank),
    .rd_sdram_addr(rd_sdram_addr), .rd_sdram_data(rd_sdram_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event history recorded by the SDRAM model, indexed by the test.
  int          act_q[$], bst_q[$], pre_q[$], ack_q[$], end_q[$];
  logic [15:0] ack_dat_q[$];
  int          proto_err = 0;
  logic [1:0]  m_bank = '0;
  logic [12:0] m_row = '0;
  logic [8:0]  m_col = '0;
  int          m_t0 = 0;
  int          m_bst = 0;
  bit          m_live = 1'b0;

  // SDRAM model: word at {bank,row,col} reads back as its low 16 address bits.
  always @(negedge clk) begin
    logic [8:0]  colw;
    logic [23:0] lin;
    case (rd_sdram_cmd)
      ACT: begin
        act_q.push_back(cyc);
        m_bank = rd_sdram_bank;
        m_row  = rd_sdram_addr;
      end
      READ: begin
        m_col  = rd_sdram_addr[8:0];
        m_t0   = cyc;
        m_bst  = 32'h3fffffff;
        m_live = 1'b1;
        if (rd_sdram_addr[12:9] != 4'd0) proto_err = proto_err + 1;
      end
      BST: begin
        bst_q.push_back(cyc);
        m_bst = cyc;
      end
      PRE: begin
        pre_q.push_back(cyc);
        if (!rd_sdram_addr[10]) proto_err = proto_err + 1;
      end
      default: ;
    endcase
    if (m_live && cyc >= m_t0 + CL && cyc < m_bst + CL) begin
      colw    = m_col + 9'(cyc - m_t0 - CL);
      lin     = {m_bank, m_row, colw};
      rd_data = lin[15:0];
    end else begin
      rd_data = 16'hDEAD;
    end
    if (rd_ack) begin
      ack_q.push_back(cyc);
      ack_dat_q.push_back(rd_sdram_data);
    end
    if (rd_end) end_q.push_back(cyc);
  end

  typedef struct {
    logic [23:0] addr;
    logic [9:0]  len;
    int n_act; int n_pre; int n_ack;
    int bst_off; int pre_off; int ack_first; int ack_last; int end_off;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Waits for acceptance and completion, then checks timing, counts and data.
  task automatic complete(input string tag, input vec_t v, input int na, input int nb,
                          input int np, input int nk, input int ne, output int ref_c);
    bit got;
    int da, dk;
    logic [23:0] s;
    ref_c = -1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rd_busy) got = 1'b1;
    end
    chk({tag, "_accept"}, longint'(got), 1);
    if (!got) return;
    ref_c = cyc;
    rd_en = 1'b0;
    rd_addr = 24'($urandom);
    rd_bst_len = 10'($urandom);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (end_q.size() > ne) got = 1'b1;
    end
    chk({tag, "_end_seen"}, longint'(got), 1);
    if (!got) return;
    repeat (4) @(negedge clk);
    chk({tag, "_end_cnt"}, end_q.size() - ne, 1);
    chk({tag, "_end_off"}, end_q[ne] - ref_c, v.end_off);
    chk({tag, "_idle"}, longint'(rd_busy), 0);
    da = act_q.size() - na;
    dk = ack_q.size() - nk;
    chk({tag, "_n_act"}, da, v.n_act);
    chk({tag, "_n_pre"}, pre_q.size() - np, v.n_pre);
    chk({tag, "_n_ack"}, dk, v.n_ack);
    if (v.n_act > 0 && da > 0) chk({tag, "_act_off"}, act_q[na] - ref_c, 0);
    if (v.n_act > 0 && bst_q.size() > nb) chk({tag, "_bst_off"}, bst_q[nb] - ref_c, v.bst_off);
    if (v.n_act > 0 && pre_q.size() > np) chk({tag, "_pre_off"}, pre_q[np] - ref_c, v.pre_off);
    if (v.n_ack > 0 && dk > 0) begin
      chk({tag, "_ack_first"}, ack_q[nk] - ref_c, v.ack_first);
      chk({tag, "_ack_last"}, ack_q[ack_q.size() - 1] - ref_c, v.ack_last);
    end
    for (int i = 0; i < dk && i < v.n_ack; i++) begin
      s = v.addr + 24'(i);
      chk($sformatf("%s_data%0d", tag, i), longint'(ack_dat_q[nk + i]), longint'(s[15:0]));
    end
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int na, nb, np, nk, ne, r;
    na = act_q.size(); nb = bst_q.size(); np = pre_q.size();
    nk = ack_q.size(); ne = end_q.size();
    @(negedge clk);
    rd_addr = v.addr;
    rd_bst_len = v.len;
    rd_en = 1'b1;
    complete(tag, v, na, nb, np, nk, ne, r);
  endtask

  vec_t vt[6];
  vec_t vx;

  initial begin
    int na, nb, np, nk, ne, r, k, bad, acks;
    vt[0] = '{24'h000000, 10'd10, 1, 1, 10, 12, 15, 6, 15, 17};
    vt[1] = '{{2'd0, 13'd5, 9'd508}, 10'd8, 2, 2, 8, 6, 9, 6, 20, 22};
    vt[2] = '{{2'd1, 13'd77, 9'd0}, 10'd1, 1, 1, 1, 3, 6, 6, 6, 8};
    vt[3] = '{24'h123456, 10'd0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4] = '{24'hFFFFFE, 10'd4, 2, 2, 4, 4, 7, 6, 16, 18};
    vt[5] = '{{2'd2, 13'd300, 9'd0}, 10'd600, 2, 2, 600, 514, 517, 6, 612, 614};

    repeat (3) @(negedge clk);
    chk("reset_cmd", longint'(rd_sdram_cmd), longint'(NOP));
    chk("reset_busy", longint'(rd_busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ack", longint'(rd_ack), 0);
    chk("post_reset_data", longint'(rd_sdram_data), 0);

    // Request held while init is incomplete must be ignored until init_end.
    vx = '{{2'd3, 13'd1000, 9'd20}, 10'd3, 1, 1, 3, 5, 8, 6, 8, 10};
    na = act_q.size(); nb = bst_q.size(); np = pre_q.size();
    nk = ack_q.size(); ne = end_q.size();
    rd_addr = vx.addr; rd_bst_len = vx.len; rd_en = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (rd_sdram_cmd != NOP || rd_busy) bad = bad + 1;
    end
    chk("init_hold_idle", bad, 0);
    init_end = 1'b1;
    k = cyc;
    complete("init", vx, na, nb, np, nk, ne, r);
    chk("init_act_latency", r, k + 1);

    for (int i = 0; i < 6; i++) run_txn($sformatf("v%0d", i), vt[i]);

    // Reset in the middle of a burst, after three words.
    @(negedge clk);
    rd_addr = 24'h000000; rd_bst_len = 10'd10; rd_en = 1'b1;
    acks = 0;
    for (int i = 0; i < 60 && acks < 3; i++) begin
      @(negedge clk);
      rd_en = 1'b0;
      if (rd_ack) acks = acks + 1;
    end
    chk("mid_acks", acks, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", longint'(rd_sdram_cmd), longint'(NOP));
    chk("mid_rst_ack", longint'(rd_ack), 0);
    chk("mid_rst_busy", longint'(rd_busy), 0);
    chk("mid_rst_data", longint'(rd_sdram_data), 0);
    chk("mid_rst_addr", longint'({rd_sdram_bank, rd_sdram_addr}), 0);
    chk("mid_rst_end", longint'(rd_end), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vx = '{24'd100, 10'd4, 1, 1, 4, 6, 9, 6, 9, 11};
    run_txn("after_rst", vx);

    chk("protocol_addr_bits", proto_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
